// File: rtl/pll_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// Holds the FSM state encoding and counter sizing helper.
package pll_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STABLE = 2'd1,
        RUN    = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_LOSS_FILTER   = 4;
    localparam int unsigned DEF_HOLD_CYCLES   = 16;

    // Counter only ever holds values up to (largest parameter - 1).
    function automatic int unsigned cnt_width(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both stages clear on the synchronous reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// Holds downstream logic in reset until the PLL lock is stable,
// and re-asserts it for a minimum time after a filtered lock loss.
module pll_reset_seq
    import pll_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned LOSS_FILTER   = DEF_LOSS_FILTER,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       core_rst,
    output logic       ready,
    output logic [7:0] lock_lost_cnt,
    output logic [1:0] state
);

    localparam int unsigned CNT_W =
        cnt_width(STABLE_CYCLES, LOSS_FILTER, HOLD_CYCLES);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             locked_s;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       lost_q;
    logic [7:0]       lost_d;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    // One counter is shared: stable run, loss filter and hold time.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = lost_q;
        unique case (state_q)
            IDLE: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOSS_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lost_q   <= '0;
            core_rst <= 1'b1;
            ready    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lost_q   <= lost_d;
            core_rst <= (state_d != RUN);
            ready    <= (state_d == RUN);
        end
    end

    assign state         = state_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq with short bench parameters.
// Expectations are queued with their due edge and checked at negedge.
module tb_pll_reset_seq;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       core_rst;
    logic       ready;
    logic [7:0] lock_lost_cnt;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [1:0] st;
        logic       crst;
        logic       rdy;
        logic [7:0] lost;
    } exp_t;

    exp_t sb[$];

    pll_reset_seq #(
        .STABLE_CYCLES (8),
        .LOSS_FILTER   (4),
        .HOLD_CYCLES   (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .locked        (locked),
        .core_rst      (core_rst),
        .ready         (ready),
        .lock_lost_cnt (lock_lost_cnt),
        .state         (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got %0d want %0d",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int dc, input string tag,
                        input logic [1:0] st, input logic crst,
                        input logic rdy, input logic [7:0] lost);
        exp_t e;
        e.cyc  = cyc + dc;
        e.tag  = tag;
        e.st   = st;
        e.crst = crst;
        e.rdy  = rdy;
        e.lost = lost;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk({sb[i].tag, "_st"},   32'(state),         32'(sb[i].st));
                chk({sb[i].tag, "_rst"},  32'(core_rst),      32'(sb[i].crst));
                chk({sb[i].tag, "_rdy"},  32'(ready),         32'(sb[i].rdy));
                chk({sb[i].tag, "_lost"}, 32'(lock_lost_cnt), 32'(sb[i].lost));
                sb.delete(i);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout at edge %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] want;
        rst    = 1'b1;
        locked = 1'b0;
        push(2, "reset", 2'd0, 1'b1, 1'b0, 8'd0);
        step(3);
        rst = 1'b0;
        push(2, "idle", 2'd0, 1'b1, 1'b0, 8'd0);
        push(4, "idle2", 2'd0, 1'b1, 1'b0, 8'd0);
        step(4);

        // lock rises, drops once at count 5, then re-locks
        locked = 1'b1;
        push(5,  "stb_a",     2'd1, 1'b1, 1'b0, 8'd0);
        push(8,  "stb_c5",    2'd1, 1'b1, 1'b0, 8'd0);
        push(9,  "stb_drop",  2'd0, 1'b1, 1'b0, 8'd0);
        push(10, "stb_re",    2'd1, 1'b1, 1'b0, 8'd0);
        push(17, "stb_early", 2'd1, 1'b1, 1'b0, 8'd0);
        push(18, "run",       2'd2, 1'b0, 1'b1, 8'd0);
        step(6);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(13);

        // 3-cycle glitch in RUN is filtered
        locked = 1'b0;
        push(3,  "gl_a", 2'd2, 1'b0, 1'b1, 8'd0);
        push(5,  "gl_b", 2'd2, 1'b0, 1'b1, 8'd0);
        push(6,  "gl_c", 2'd2, 1'b0, 1'b1, 8'd0);
        push(10, "gl_d", 2'd2, 1'b0, 1'b1, 8'd0);
        step(3);
        locked = 1'b1;
        step(10);

        // real loss, re-lock during HOLD
        locked = 1'b0;
        push(5,  "loss_pre",  2'd2, 1'b0, 1'b1, 8'd0);
        push(6,  "loss",      2'd3, 1'b1, 1'b0, 8'd1);
        push(10, "hold_rl",   2'd3, 1'b1, 1'b0, 8'd1);
        push(11, "hold_end",  2'd0, 1'b1, 1'b0, 8'd1);
        push(12, "restb",     2'd1, 1'b1, 1'b0, 8'd1);
        push(19, "restb_end", 2'd1, 1'b1, 1'b0, 8'd1);
        push(20, "rerun",     2'd2, 1'b0, 1'b1, 8'd1);
        step(7);
        locked = 1'b1;
        step(14);

        // drive the loss counter into saturation
        for (int i = 1; i <= 255; i++) begin
            want = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            locked = 1'b0;
            push(6, "sat", 2'd3, 1'b1, 1'b0, want);
            step(7);
            locked = 1'b1;
            step(14);
        end
        push(1, "sat_run", 2'd2, 1'b0, 1'b1, 8'd255);
        step(2);

        // one-cycle reset mid-RUN
        rst = 1'b1;
        push(1, "rst_mid", 2'd0, 1'b1, 1'b0, 8'd0);
        step(1);
        rst = 1'b0;
        push(2,  "rst_r3",  2'd0, 1'b1, 1'b0, 8'd0);
        push(3,  "rst_stb", 2'd1, 1'b1, 1'b0, 8'd0);
        push(10, "rst_pre", 2'd1, 1'b1, 1'b0, 8'd0);
        push(11, "rst_run", 2'd2, 1'b0, 1'b1, 8'd0);
        step(14);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter STABLE_CYCLES, default 1024: consecutive cycles that the synchronised lock must stay high before core reset releases; legal range 1..65535.
REQ-002 Parameter LOSS_FILTER, default 4: consecutive cycles that the synchronised lock must stay low in RUN before a lock loss is declared; legal range 1..255.
REQ-003 Parameter HOLD_CYCLES, default 16: minimum cycles core_rst stays asserted after a declared lock loss; legal range 1..65535.
REQ-004 clk  input  1  PLL output clock (clk10); the block's only clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 locked  input  1  PLL LOCK, asynchronous to clk.
REQ-007 core_rst  output  1  active-high synchronous reset for downstream logic.
REQ-008 ready  output  1  high exactly when the state is RUN.
REQ-009 lock_lost_cnt  output  8  saturating count of declared lock losses.
REQ-010 state  output  2  current state encoding, for debug.

Function
REQ-011 locked SHALL pass through a two-flop synchronizer; the result is locked_s, which lags locked by 2 edges.
REQ-012 The state machine SHALL have four states: IDLE=0, STABLE=1, RUN=2, HOLD=3.
REQ-013 IDLE: when locked_s=1 at an edge, go to STABLE and clear the counter; otherwise stay in IDLE.
REQ-014 STABLE: at each edge with locked_s=1, increment the counter; when the counter equals STABLE_CYCLES-1, go to RUN; when locked_s=0, go to IDLE.
REQ-015 RUN: count consecutive edges with locked_s=0 and clear that count when locked_s=1; at the LOSS_FILTER-th consecutive low edge, go to HOLD and increment lock_lost_cnt.
REQ-016 HOLD: locked_s is ignored; the counter counts edges; after HOLD_CYCLES edges in HOLD, go to IDLE.
REQ-017 lock_lost_cnt SHALL saturate at 255 and never wrap.
REQ-018 core_rst and ready SHALL be registered outputs that update on the same edge as the state change: core_rst=0 and ready=1 only in RUN.
REQ-019 Timing from locked rising: if locked is first sampled high at edge e0 and stays high, the state is RUN and core_rst=0 after edge e0+2+STABLE_CYCLES.
REQ-020 Timing of lock loss: from the first edge where locked_s=0 in RUN, core_rst rises after exactly LOSS_FILTER edges.
REQ-021 A locked_s low pulse of LOSS_FILTER-1 cycles or fewer in RUN SHALL have no effect on any output.
REQ-022 Re-lock during HOLD SHALL NOT shorten HOLD; the IDLE to STABLE sequence restarts after HOLD ends.
REQ-023 A single shared counter SHALL serve STABLE, the RUN loss filter and HOLD.
REQ-024 The counter width SHALL be sized by clog2 of the largest parameter, and the counter SHALL never wrap within a state.

Reset
REQ-025 With rst=1 at an edge: state=IDLE, core_rst=1, ready=0, lock_lost_cnt=0, counter=0 and both synchronizer flops=0.
REQ-026 rst asserted in any state, including mid-RUN or mid-HOLD, SHALL take effect at that edge; there is no asynchronous path.
REQ-027 After rst falls, the sequence restarts per REQ-019, measured from the first edge with rst=0.

Structure
REQ-028 Package pll_pkg SHALL hold the state enum (IDLE, STABLE, RUN, HOLD) and the default STABLE_CYCLES, LOSS_FILTER and HOLD_CYCLES constants.
REQ-029 The synchronizer SHALL be a separate sub-module sync2 (two flops, 1-bit, reset to 0), instantiated once.
REQ-030 The state machine and counters SHALL be in pll_reset_seq; the implementation SHALL stay within 120-400 lines.

Verification
REQ-031 Bench parameters: STABLE_CYCLES=8, LOSS_FILTER=4, HOLD_CYCLES=5; locked rises at e0 and stays high -> core_rst falls and ready rises after e10, state=2.
REQ-032 In STABLE, locked low for 1 cycle at count 5 -> return to IDLE; the full 8-cycle count restarts; core_rst is never released early.
REQ-033 In RUN, a 3-cycle locked low glitch -> no output change, lock_lost_cnt=0.
REQ-034 In RUN, locked held low -> core_rst=1 four edges after the first locked_s=0; lock_lost_cnt=1; HOLD lasts 5 edges, then IDLE; with locked high, RUN returns 1+8 edges after leaving HOLD.
REQ-035 Force 256 lock losses -> lock_lost_cnt reads 255 and stays at 255.
REQ-036 rst pulsed for 1 cycle mid-RUN -> core_rst=1, ready=0 and state=0 at that edge; lock_lost_cnt=0.
